// File: rtl/detector_jogada_pkg.sv
// Shared constants for the play detector: FSM state codes and default debounce length.
// Latency: n/a (constants only).
// Backpressure: n/a.
package detector_jogada_pkg;

    // FSM state encodings, also exported on db_estado for debug
    localparam logic [2:0] OCIOSO       = 3'd0;
    localparam logic [2:0] FILTRA       = 3'd1;
    localparam logic [2:0] PULSO        = 3'd2;
    localparam logic [2:0] INVALIDO     = 3'd3;
    localparam logic [2:0] ESPERA_SOLTA = 3'd4;
    localparam logic [2:0] FILTRA_SOLTA = 3'd5;

    // 1 ms of stable input at 50 MHz
    localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (buttons, jogar).
// Latency: 2 clock cycles from input change to output change.
// Backpressure: none; the input is sampled every cycle.
module sincronizador_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] dado,
    output logic [WIDTH-1:0] sincronizado
);

    logic [WIDTH-1:0] meta;

    // first flop absorbs metastability, second presents a settled value
    always_ff @(posedge clock) begin
        if (reset) begin
            meta         <= '0;
            sincronizado <= '0;
        end else begin
            meta         <= dado;
            sincronizado <= meta;
        end
    end

endmodule

// File: rtl/detector_jogada.sv
// Button front end: synchronise, debounce, check one-hot, emit one pulse per press.
// Latency: stable raw press first sampled at edge k -> tem_jogada in cycle after edge k+DEBOUNCE_CICLOS+2.
// Backpressure: habilita gates acceptance; presses seen while it is low need a full release first.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                habilita,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                jogada_invalida,
    output logic [2:0]          db_estado
);

    localparam int                   CW       = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0]        CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0]        CONT_UM  = CW'(1);
    localparam logic [N_BOTOES-1:0]  BOTAO_UM = N_BOTOES'(1);

    logic [N_BOTOES-1:0] bs;
    logic [N_BOTOES-1:0] snapshot;
    logic [CW-1:0]       contador;
    logic [2:0]          estado;
    logic                snapshot_one_hot;

    sincronizador_2ff #(
        .WIDTH (N_BOTOES)
    ) u_sinc_botoes (
        .clock        (clock),
        .reset        (reset),
        .dado         (botoes),
        .sincronizado (bs)
    );

    // exactly one button: non-zero and clearing the lowest set bit leaves nothing
    assign snapshot_one_hot = (snapshot != '0) &&
                              ((snapshot & (snapshot - BOTAO_UM)) == '0);

    // press/release debounce FSM; the counter is cleared on every entry to a filter state
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            contador <= '0;
            snapshot <= '0;
            jogada   <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bs != '0) begin
                        if (habilita) begin
                            snapshot <= bs;
                            contador <= '0;
                            estado   <= FILTRA;
                        end else begin
                            // pressed while disabled: demand a full release before any play
                            estado <= ESPERA_SOLTA;
                        end
                    end
                end
                FILTRA: begin
                    if (!habilita) begin
                        estado <= ESPERA_SOLTA;
                    end else if (bs == '0) begin
                        estado <= OCIOSO;
                    end else if (bs != snapshot) begin
                        snapshot <= bs;
                        contador <= '0;
                    end else if (contador == CONT_MAX) begin
                        if (snapshot_one_hot) begin
                            jogada <= snapshot;
                            estado <= PULSO;
                        end else begin
                            estado <= INVALIDO;
                        end
                    end else begin
                        contador <= contador + CONT_UM;
                    end
                end
                PULSO, INVALIDO: begin
                    estado <= ESPERA_SOLTA;
                end
                ESPERA_SOLTA: begin
                    if (bs == '0) begin
                        contador <= '0;
                        estado   <= FILTRA_SOLTA;
                    end
                end
                FILTRA_SOLTA: begin
                    if (bs != '0) begin
                        estado <= ESPERA_SOLTA;
                    end else if (contador == CONT_MAX) begin
                        estado <= OCIOSO;
                    end else begin
                        contador <= contador + CONT_UM;
                    end
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    assign tem_jogada      = (estado == PULSO);
    assign jogada_invalida = (estado == INVALIDO);
    assign db_estado       = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada with DEBOUNCE_CICLOS=4, N_BOTOES=4.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_detector_jogada;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [3:0] botoes;
    logic       habilita;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic       jogada_invalida;
    logic [2:0] db_estado;

    int n_comp  = 0;
    int n_falha = 0;

    // reference model: delay line for the synchroniser plus run-length bookkeeping
    logic [3:0] m_s1, m_s2, m_cand, m_jog;
    int         m_run, m_solta;
    bit         m_armado, m_morto, m_tem, m_inv;

    detector_jogada #(
        .N_BOTOES        (4),
        .DEBOUNCE_CICLOS (D)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .botoes          (botoes),
        .habilita        (habilita),
        .tem_jogada      (tem_jogada),
        .jogada          (jogada),
        .jogada_invalida (jogada_invalida),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge: update the model from the inputs present at the edge, then settle.
    // Armed: a press is accepted after D+1 consecutive identical non-zero synchronised samples.
    // Disarmed: D+1 consecutive zero samples are needed; the edge after a decision is dead.
    task automatic avanca();
        logic [3:0] bs;
        @(posedge clock);
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_cand = '0; m_jog = '0;
            m_run = 0; m_solta = 0;
            m_armado = 1; m_morto = 0; m_tem = 0; m_inv = 0;
        end else begin
            bs    = m_s2;
            m_tem = 0;
            m_inv = 0;
            if (m_morto) begin
                m_morto = 0;
            end else if (m_armado) begin
                if (!habilita && (m_run > 0 || bs != 0)) begin
                    m_armado = 0; m_solta = 0; m_run = 0;
                end else if (bs == 0) begin
                    m_run = 0;
                end else if (m_run > 0 && bs == m_cand) begin
                    m_run++;
                end else begin
                    m_cand = bs;
                    m_run  = 1;
                end
                if (m_run == D + 1) begin
                    if ($countones(m_cand) == 1) begin
                        m_tem = 1;
                        m_jog = m_cand;
                    end else begin
                        m_inv = 1;
                    end
                    m_armado = 0; m_solta = 0; m_run = 0; m_morto = 1;
                end
            end else begin
                if (bs == 0) m_solta++;
                else         m_solta = 0;
                if (m_solta == D + 1) begin
                    m_armado = 1;
                    m_run    = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = botoes;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; habilita = 1; botoes = 4'b1111;
        for (int i = 0; i < 3; i++) avanca();
        if ({tem_jogada, jogada_invalida, jogada, db_estado} !== 9'd0) begin
            $display("FAIL reset: tem=%b inv=%b jog=%b est=%0d, want all 0",
                     tem_jogada, jogada_invalida, jogada, db_estado);
            n_falha++;
        end
        n_comp++;
        botoes = 0;
        reset  = 0;
        for (int i = 0; i < 4; i++) avanca();
    endtask

    task automatic test_press_limpo();
        int idx = -1;
        int np  = 0;
        habilita = 1; botoes = 4'b0100;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) botoes = 0;
            avanca();
            if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                $display("FAIL limpo c%0d: tem=%b inv=%b jog=%b want %b %b %b",
                         i, tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                n_falha++;
            end
            n_comp++;
            if (tem_jogada) begin np++; if (idx < 0) idx = i; end
        end
        if (idx !== 6 || np !== 1) begin
            $display("FAIL limpo_latencia: edge=%0d pulses=%0d, want edge 6 pulses 1", idx, np);
            n_falha++;
        end
        n_comp++;
        if (jogada !== 4'b0100) begin
            $display("FAIL limpo_retido: jog=%b want 0100", jogada);
            n_falha++;
        end
        n_comp++;
    endtask

    task automatic test_bounce();
        int idx = -1;
        int np  = 0;
        habilita = 1;
        for (int i = 0; i < 32; i++) begin
            if (i < 10)      botoes = (((i / 2) % 2) == 0) ? 4'b0100 : 4'b0000;
            else if (i < 20) botoes = 4'b0100;
            else             botoes = 4'b0000;
            avanca();
            if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                $display("FAIL bounce c%0d: tem=%b inv=%b jog=%b want %b %b %b",
                         i, tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                n_falha++;
            end
            n_comp++;
            if (tem_jogada) begin np++; if (idx < 0) idx = i; end
        end
        if (idx !== 14 || np !== 1) begin
            $display("FAIL bounce_pulso: edge=%0d pulses=%0d, want edge 14 pulses 1", idx, np);
            n_falha++;
        end
        n_comp++;
    endtask

    task automatic test_dois_botoes();
        int ninv = 0;
        int ntem = 0;
        habilita = 1;
        for (int i = 0; i < 24; i++) begin
            botoes = (i < 12) ? 4'b0011 : 4'b0000;
            avanca();
            if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                $display("FAIL dois c%0d: tem=%b inv=%b jog=%b want %b %b %b",
                         i, tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                n_falha++;
            end
            n_comp++;
            if (jogada_invalida) ninv++;
            if (tem_jogada)      ntem++;
        end
        if (ninv !== 1 || ntem !== 0 || jogada !== 4'b0100) begin
            $display("FAIL dois_resumo: inv=%0d tem=%0d jog=%b, want 1 0 0100", ninv, ntem, jogada);
            n_falha++;
        end
        n_comp++;
    endtask

    task automatic test_segurado();
        int np_curto = 0;
        int np       = 0;
        habilita = 1;
        for (int i = 0; i < 112; i++) begin
            if (i < 50)       botoes = 4'b0001;
            else if (i < 52)  botoes = 4'b0000;
            else if (i < 72)  botoes = 4'b0001;
            else if (i < 80)  botoes = 4'b0000;
            else if (i < 100) botoes = 4'b0001;
            else              botoes = 4'b0000;
            avanca();
            if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                $display("FAIL segurado c%0d: tem=%b inv=%b jog=%b want %b %b %b",
                         i, tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                n_falha++;
            end
            n_comp++;
            if (tem_jogada) begin np++; if (i < 72) np_curto++; end
        end
        if (np_curto !== 1 || np !== 2 || jogada !== 4'b0001) begin
            $display("FAIL segurado_resumo: ate72=%0d total=%0d jog=%b, want 1 2 0001",
                     np_curto, np, jogada);
            n_falha++;
        end
        n_comp++;
    endtask

    task automatic test_habilita();
        int np_bloq = 0;
        int np      = 0;
        for (int i = 0; i < 70; i++) begin
            habilita = (i >= 6);
            if (i < 26)      botoes = 4'b1000;
            else if (i < 38) botoes = 4'b0000;
            else if (i < 58) botoes = 4'b1000;
            else             botoes = 4'b0000;
            avanca();
            if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                $display("FAIL habilita c%0d: tem=%b inv=%b jog=%b want %b %b %b",
                         i, tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                n_falha++;
            end
            n_comp++;
            if (tem_jogada) begin np++; if (i < 38) np_bloq++; end
        end
        if (np_bloq !== 0 || np !== 1 || jogada !== 4'b1000) begin
            $display("FAIL habilita_resumo: bloqueado=%0d total=%0d jog=%b, want 0 1 1000",
                     np_bloq, np, jogada);
            n_falha++;
        end
        n_comp++;
    endtask

    task automatic test_reset_filtro();
        int np = 0;
        habilita = 1; botoes = 4'b0010;
        for (int i = 0; i < 4; i++) avanca();
        if (db_estado !== 3'd1) begin
            $display("FAIL rst_filtro_estado: est=%0d want 1", db_estado);
            n_falha++;
        end
        n_comp++;
        reset = 1;
        avanca();
        reset = 0;
        if ({tem_jogada, jogada_invalida, jogada, db_estado} !== 9'd0) begin
            $display("FAIL rst_filtro_zera: tem=%b inv=%b jog=%b est=%0d, want all 0",
                     tem_jogada, jogada_invalida, jogada, db_estado);
            n_falha++;
        end
        n_comp++;
        for (int i = 0; i < 28; i++) begin
            if (i == 16) botoes = 0;
            avanca();
            if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                $display("FAIL rst_filtro c%0d: tem=%b inv=%b jog=%b want %b %b %b",
                         i, tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                n_falha++;
            end
            n_comp++;
            if (tem_jogada) np++;
        end
        if (np !== 1 || jogada !== 4'b0010) begin
            $display("FAIL rst_filtro_repress: pulses=%0d jog=%b, want 1 0010", np, jogada);
            n_falha++;
        end
        n_comp++;
    endtask

    task automatic test_aleatorio();
        logic [3:0] v;
        int         sel, len;
        for (int e = 0; e < 120; e++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      v = 4'b0001 << $urandom_range(0, 3);
            else if (sel < 8) v = 4'($urandom_range(1, 15));
            else              v = 4'b0000;
            len      = int'($urandom_range(1, 12));
            habilita = ($urandom_range(0, 7) != 0);
            botoes   = v;
            for (int i = 0; i < len; i++) begin
                avanca();
                if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                    $display("FAIL aleatorio ep%0d c%0d: tem=%b inv=%b jog=%b want %b %b %b",
                             e, i, tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                    n_falha++;
                end
                n_comp++;
            end
        end
    endtask

    initial begin
        reset = 1; habilita = 1; botoes = 0;
        test_reset();
        test_press_limpo();
        test_bounce();
        test_dois_botoes();
        test_segurado();
        test_habilita();
        test_reset_filtro();
        test_aleatorio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
        $finish;
    end

endmodule
